// File: rtl/fpadd_issue.sv
// fpadd_issue: operand FIFO plus single-outstanding issue/capture stage in
// front of the multi-cycle single-precision adder. Results are returned with
// their tag over a valid/ready port. Define FPADD_ISSUE_WDOG_EN to enable the
// WAIT-state watchdog that turns a hung adder operation into a flagged qNaN.
module fpadd_issue #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [3:0]  in_tag,
   output logic        add_start,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_sum,
   input  logic        add_done,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sum,
   output logic [3:0]  out_tag,
   output logic        out_err,
   output logic        busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;
   localparam cnt_t FULL_CNT = cnt_t'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_t;
   state_t state;

   logic [31:0] mem_a   [FIFO_DEPTH];
   logic [31:0] mem_b   [FIFO_DEPTH];
   logic [3:0]  mem_tag [FIFO_DEPTH];
   ptr_t        wr_ptr, rd_ptr;
   cnt_t        count;
   logic        push, pop, empty;

   logic [31:0] op_a, op_b;
   logic [3:0]  op_tag;

`ifdef FPADD_ISSUE_WDOG_EN
   localparam int unsigned WW = $clog2(TIMEOUT);
   typedef logic [WW-1:0] wd_t;
   localparam wd_t WDOG_LAST = wd_t'(TIMEOUT - 1);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   wd_t  wdog_cnt;
   logic err_q;
   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

   // in_ready depends on occupancy only, so a same-cycle pop never raises it
   assign empty    = (count == '0);
   assign in_ready = (count != FULL_CNT);
   assign push     = in_valid && in_ready;
   assign pop      = (state == S_IDLE) && !empty;
   assign add_a    = op_a;
   assign add_b    = op_b;
   assign busy     = (state != S_IDLE) || !empty;

   // FIFO storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]   <= in_a;
         mem_b[wr_ptr]   <= in_b;
         mem_tag[wr_ptr] <= in_tag;
      end
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ptr_t'(1);
         if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
         unique case ({push, pop})
            2'b10:   count <= count + cnt_t'(1);
            2'b01:   count <= count - cnt_t'(1);
            default: count <= count;
         endcase
      end
   end

   // Issue/capture FSM; add_done is only looked at in WAIT, so a sticky done
   // left over from the previous operation is ignored during START
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         op_a      <= '0;
         op_b      <= '0;
         op_tag    <= '0;
         add_start <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_tag   <= '0;
`ifdef FPADD_ISSUE_WDOG_EN
         wdog_cnt  <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (!empty) begin
                  op_a      <= mem_a[rd_ptr];
                  op_b      <= mem_b[rd_ptr];
                  op_tag    <= mem_tag[rd_ptr];
                  add_start <= 1'b1;
                  state     <= S_START;
               end
            end
            S_START: begin
               add_start <= 1'b0;
`ifdef FPADD_ISSUE_WDOG_EN
               wdog_cnt  <= '0;
`endif
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (add_done) begin
                  out_sum   <= add_sum;
                  out_tag   <= op_tag;
                  out_valid <= 1'b1;
`ifdef FPADD_ISSUE_WDOG_EN
                  err_q     <= 1'b0;
`endif
                  state     <= S_HOLD;
               end
`ifdef FPADD_ISSUE_WDOG_EN
               else if (wdog_cnt == WDOG_LAST) begin
                  out_sum   <= QNAN;
                  out_tag   <= op_tag;
                  out_valid <= 1'b1;
                  err_q     <= 1'b1;
                  state     <= S_HOLD;
               end else begin
                  wdog_cnt  <= wdog_cnt + wd_t'(1);
               end
`endif
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fpadd_issue.md
# fpadd_issue

Operand issue and result capture stage placed directly upstream of the multi-cycle single-precision adder. Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. Drives the adder's level `start` / sticky `done` protocol one operation at a time, then presents each sum, with its tag, on a valid/ready output. An optional watchdog converts a hung adder operation into a flagged qNaN result.

## Interface
- `FIFO_DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: watchdog limit in cycles spent in WAIT; ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high; shared with the adder.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO not full.
- `in_a`, `in_b` in 32: IEEE-754 single operands.
- `in_tag` in 4: opaque tag, returned with the result.
- `add_start` out 1: adder start pulse.
- `add_a`, `add_b` out 32: adder operands.
- `add_sum` in 32: adder result.
- `add_done` in 1: adder sticky done.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result accepted.
- `out_sum` out 32: result.
- `out_tag` out 4: tag of the result.
- `out_err` out 1: result produced by watchdog.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.

## Operation
- **FIFO**
  - Push on `in_valid && in_ready`.
  - `in_ready = !full`, a function of occupancy only. A pop in the same cycle does not raise `in_ready`.
  - No fall-through: a word pushed at edge N is poppable at edge N+1 at the earliest.
  - Pointers wrap modulo `FIFO_DEPTH`. Count is `log2(FIFO_DEPTH)+1` bits.
- **FSM states:** IDLE, START, WAIT, HOLD.
- **IDLE**
  - If FIFO non-empty: pop into registers `op_a`, `op_b`, `op_tag`, then go to START.
  - Otherwise stay.
- **START**
  - `add_start=1` for exactly this one cycle.
  - Clear watchdog counter.
  - Go to WAIT.
- **WAIT**
  - `add_start=0`.
  - If `add_done=1`: capture `add_sum` into `out_sum`, `op_tag` into `out_tag`, clear `out_err`, go to HOLD.
  - Otherwise increment the watchdog counter.
- **HOLD**
  - `out_valid=1`.
  - On `out_ready=1`: drop `out_valid`, go to IDLE.
  - `out_sum`, `out_tag` and `out_err` stay stable while `out_valid && !out_ready`.
- **Adder operands:** `add_a`, `add_b` are driven from `op_a`, `op_b`. They change only on the IDLE→START pop and are stable through START, WAIT and HOLD.
- **Stale `done`:** `add_done` is never sampled in IDLE or START. The adder's `done` from the previous operation may still be high in the START cycle and must be ignored.
- **No arithmetic:** the block does no arithmetic on operand or sum fields. Data passes through bit-exact.

## Timing
- **Reset values:**
  - `in_ready=1`
  - `add_start=0`, `add_a=0`, `add_b=0`
  - `out_valid=0`, `out_sum=0`, `out_tag=0`, `out_err=0`
  - `busy=0`
  - FIFO empty, state IDLE.
- **Mid-operation reset:** `reset` asserted in any state discards FIFO contents and any in-flight operation. The block is IDLE on the following cycle.
- **Reset priority:** `reset` has priority over every simultaneous handshake.
- **Issue latency:** input handshake at edge N into an empty FIFO, with state IDLE:
  - pop at edge N+1;
  - `add_start` high during cycle N+1..N+2;
  - WAIT from edge N+2.
- **Result latency:** `add_done` first sampled high in WAIT at edge M gives `out_valid` high from edge M.
- **Throughput:** at most one operation in flight. Minimum spacing between `add_start` pulses is 4 cycles plus the adder latency (when `out_ready` is held high).
- **Simultaneous push in HOLD:** a push arriving while in HOLD with `out_ready=1` is buffered normally. It issues via IDLE on the next cycles.
- **Full FIFO:** `in_valid` is ignored and the upstream producer must hold its data.

## Configuration
- **`FPADD_ISSUE_WDOG_EN` defined:** in WAIT, if the counter reaches `TIMEOUT-1` with `add_done=0`:
  - `out_sum=32'h7FC00000`, `out_err=1`, `out_tag=op_tag`;
  - go to HOLD.
  - A `done` arriving later is ignored, because the next START re-arms the adder.
- **Not defined:** the counter logic is omitted, WAIT waits indefinitely, and `out_err` is tied 0.

## Test plan
- **Single op:** push {`3F800000`, `40000000`, tag 5}. Adder model returns `40400000` with `done` 8 cycles after `start`. Expect:
  - one `add_start` pulse, at edge 1 after the handshake;
  - `out_sum=40400000`, `out_tag=5`, `out_err=0`.
- **Stale done:** model holds `done=1` from the previous op through the next START cycle. Expect the block to stay in WAIT until `done` reasserts. Expect no premature result.
- **Back-pressure:** push 6 pairs with `out_ready=0`. Expect:
  - `in_ready` low after FIFO_DEPTH+1 accepts (FIFO + op regs);
  - on release, results emerge in order with tags 0..5.
- **Output stall:** hold `out_ready=0` for 10 cycles in HOLD. Expect `out_sum` and `out_tag` stable, and no further `add_start`.
- **Watchdog (macro on, `TIMEOUT`=16):** adder never asserts `done`. Expect `out_sum=7FC00000`, `out_err=1` at the 16th WAIT cycle. Expect the next op to proceed normally.
- **Reset mid-WAIT with 3 queued:** expect the block IDLE next cycle with `busy=0`, `out_valid=0`, `in_ready=1`. Expect no `add_start` afterwards.
